// File: rtl/dmem_ctrl.sv
// Data memory controller: byte-addressed load/store front end over a 32-bit word
// array with fixed request latency, load-lane formatting and misaligned/illegal flagging.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        dram_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] adr,
    input  logic [31:0] rD2,
    output logic [31:0] rd,
    output logic        ready,
    output logic        done,
    output logic        err
);

    // state  | meaning
    // S_IDLE | ready for a request; stores commit at the accepting edge
    // S_WAIT | latency countdown, requests ignored
    // S_DONE | one-cycle completion; load data and err presented
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW+1:0]   adr_q;
    logic [2:0]      f3_q;
    logic            we_q;
    logic            err_q;
    logic [31:0]     rd_q, rd_d;

    logic            accept;
    logic            req_illegal;
    logic            req_misaligned;
    logic            req_err;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic [AW-1:0]   wr_idx;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     ld_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
    logic            ld_fire;

    // Upper address bits alias onto the array.
    logic            unused_adr_hi;
    assign unused_adr_hi = ^adr[31:AW+2];

    assign accept = (state_q == S_IDLE) && req;
    assign wr_idx = adr[AW+1:2];

    assign req_illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                            (funct3[2] && dram_we);
    assign req_misaligned = ((funct3[1:0] == 2'b01) && adr[0]) ||
                            ((funct3[1:0] == 2'b10) && (adr[1:0] != 2'b00));
    assign req_err        = req_illegal || req_misaligned;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << adr[1:0];
                wr_data = {4{rD2[7:0]}};
            end
            2'b01: begin
                wr_be   = adr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{rD2[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = rD2;
            end
            default: ;
        endcase
    end

    // Array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && dram_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            adr_q   <= '0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            if (accept) begin
                adr_q <= adr[AW+1:0];
                f3_q  <= funct3;
                we_q  <= dram_we;
                err_q <= req_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (RD_LAT == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        case (state_q)
            S_IDLE: ready = 1'b1;
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // No store can be accepted between acceptance and DONE, so the array word is stable here.
    assign ld_word = mem_q[adr_q[AW+1:2]];

    always_comb begin
        case (adr_q[1:0])
            2'b00:   ld_byte = ld_word[7:0];
            2'b01:   ld_byte = ld_word[15:8];
            2'b10:   ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = adr_q[1] ? ld_word[31:16] : ld_word[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    assign ld_fire = (state_q == S_DONE) && !we_q && !err_q;
    assign rd_d    = ld_fire ? ld_data : rd_q;
    assign rd      = rd_d;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, randomized traffic against
// a word-array reference model, latency/back-pressure and reset-abort sequences.
module tb_dmem_ctrl;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        req1 = 1'b0;
    logic        req3 = 1'b0;
    logic        we   = 1'b0;
    logic [2:0]  f3   = 3'd0;
    logic [31:0] adr  = 32'h0;
    logic [31:0] wd   = 32'h0;

    logic [31:0] rd1, rd3;
    logic        ready1, ready3, done1, done3, err1, err3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mmem [2][4096];
    logic [31:0] mrd  [2];

    typedef struct {
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    dmem_ctrl #(.DEPTH_WORDS(4096), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .dram_we(we), .funct3(f3), .adr(adr),
        .rD2(wd), .rd(rd1), .ready(ready1), .done(done1), .err(err1)
    );

    dmem_ctrl #(.DEPTH_WORDS(4096), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .dram_we(we), .funct3(f3), .adr(adr),
        .rD2(wd), .rd(rd3), .ready(ready3), .done(done3), .err(err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory semantics on a plain word array.
    function automatic void model_op(input int d, input logic w, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] dat,
                                     output logic [31:0] e_rd, output logic e_err);
        logic [31:0] word;
        logic [31:0] lane;
        int          sh;
        int          idx;
        e_err = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (f[2] && w) ||
                (((f == 3'd1) || (f == 3'd5)) && a[0]) ||
                ((f == 3'd2) && (a[1:0] != 2'd0));
        idx  = int'(a[13:2]);
        sh   = int'(a[1:0]) * 8;
        word = mmem[d][idx];
        if (!e_err) begin
            if (w) begin
                case (f)
                    3'd0:    word[sh +: 8]  = dat[7:0];
                    3'd1:    word[sh +: 16] = dat[15:0];
                    default: word = dat;
                endcase
                mmem[d][idx] = word;
            end else begin
                lane = word >> sh;
                case (f)
                    3'd0:    mrd[d] = {{24{lane[7]}}, lane[7:0]};
                    3'd4:    mrd[d] = {24'h0, lane[7:0]};
                    3'd1:    mrd[d] = {{16{lane[15]}}, lane[15:0]};
                    3'd5:    mrd[d] = {16'h0, lane[15:0]};
                    default: mrd[d] = word;
                endcase
            end
        end
        e_rd = mrd[d];
    endfunction

    task automatic access(input int d, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] dat,
                          output logic [31:0] o_rd, output logic o_err, output int o_lat);
        @(negedge clk);
        we  = w;
        f3  = f;
        adr = a;
        wd  = dat;
        if (d == 0) req1 = 1'b1;
        else        req3 = 1'b1;
        chk("ready_before_req", {31'b0, (d == 0) ? ready1 : ready3}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1  = 1'b0;
        req3  = 1'b0;
        o_lat = 1;
        while ((((d == 0) ? done1 : done3) == 1'b0) && (o_lat < 12)) begin
            chk("err_low_without_done", {31'b0, (d == 0) ? err1 : err3}, 32'd0);
            @(negedge clk);
            o_lat++;
        end
        if (o_lat >= 12) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: actual=no_done required=done within %0d cycles", 12);
        end
        o_rd  = (d == 0) ? rd1 : rd3;
        o_err = (d == 0) ? err1 : err3;
    endtask

    task automatic run_op(input int d, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] dat);
        logic [31:0] e_rd, g_rd;
        logic        e_err, g_err;
        int          lat;
        model_op(d, w, f, a, dat, e_rd, e_err);
        access(d, w, f, a, dat, g_rd, g_err, lat);
        chk("rand_rd", g_rd, e_rd);
        chk("rand_err", {31'b0, g_err}, {31'b0, e_err});
        chk("rand_latency", 32'(lat), (d == 0) ? 32'd1 : 32'd3);
    endtask

    initial begin
        logic [31:0] e_rd, g_rd, a;
        logic        e_err, g_err;
        int          lat;

        tbl[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        tbl[3]  = '{1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        tbl[4]  = '{1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
        tbl[5]  = '{1'b0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
        tbl[6]  = '{1'b1, 3'b000, 32'h11,   32'h55,       32'h0000BEEF, 1'b0};
        tbl[7]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 32'h12,   32'h0,        32'hDEAD55EF, 1'b1};
        tbl[9]  = '{1'b1, 3'b001, 32'h11,   32'hAAAA,     32'hDEAD55EF, 1'b1};
        tbl[10] = '{1'b0, 3'b011, 32'h10,   32'h0,        32'hDEAD55EF, 1'b1};
        tbl[11] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
        tbl[12] = '{1'b1, 3'b100, 32'h10,   32'h0,        32'hDEAD55EF, 1'b1};
        tbl[13] = '{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
        tbl[14] = '{1'b1, 3'b010, 32'h4000, 32'h12345678, 32'hDEAD55EF, 1'b0};
        tbl[15] = '{1'b0, 3'b010, 32'h0,    32'h0,        32'h12345678, 1'b0};

        mrd[0] = 32'h0;
        mrd[1] = 32'h0;

        #1 rst = 1'b1;
        #1;
        chk("reset_rd1",    rd1,              32'h0);
        chk("reset_ready1", {31'b0, ready1},  32'd1);
        chk("reset_done1",  {31'b0, done1},   32'd0);
        chk("reset_err1",   {31'b0, err1},    32'd0);
        chk("reset_rd3",    rd3,              32'h0);
        chk("reset_ready3", {31'b0, ready3},  32'd1);
        chk("reset_done3",  {31'b0, done3},   32'd0);
        chk("reset_err3",   {31'b0, err3},    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            model_op(0, tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].dat, e_rd, e_err);
            access(0, tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].dat, g_rd, g_err, lat);
            chk($sformatf("tbl%0d_rd", i), g_rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), {31'b0, g_err}, {31'b0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd1);
        end

        // Randomized traffic over eight words, with random aliasing upper address bits.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) begin
                a = $urandom;
                a[13:0] = 14'(w * 4);
                run_op(d, 1'b1, 3'b010, a, $urandom);
            end
            for (int n = 0; n < 120; n++) begin
                a = $urandom;
                a[13:5] = 9'd0;
                run_op(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            end
        end

        // Back-to-back request held high on the RD_LAT=3 instance.
        model_op(1, 1'b0, 3'b010, 32'h10, 32'h0, e_rd, e_err);
        @(negedge clk);
        we = 1'b0; f3 = 3'b010; adr = 32'h10; wd = 32'h0; req3 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold_ready_c%0d", c), {31'b0, ready3}, 32'd0);
            chk($sformatf("hold_done_c%0d", c), {31'b0, done3}, (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) chk("hold_rd_first", rd3, e_rd);
        end
        @(negedge clk);
        chk("hold_ready_c4", {31'b0, ready3}, 32'd1);
        chk("hold_done_c4",  {31'b0, done3},  32'd0);
        model_op(1, 1'b0, 3'b010, 32'h10, 32'h0, e_rd, e_err);
        @(posedge clk);
        @(negedge clk);
        chk("hold_reaccept", {31'b0, ready3}, 32'd0);
        req3 = 1'b0;
        lat = 1;
        while (!done3 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_second_latency", 32'(lat), 32'd3);
        chk("hold_rd_second", rd3, e_rd);

        // Reset while a store is in WAIT: no done, rd cleared, store retained.
        @(negedge clk);
        a = $urandom;
        model_op(1, 1'b1, 3'b010, 32'h18, a, e_rd, e_err);
        we = 1'b1; f3 = 3'b010; adr = 32'h18; wd = a; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        chk("abort_in_wait", {31'b0, ready3}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_rd3",    rd3,             32'h0);
        chk("abort_ready3", {31'b0, ready3}, 32'd1);
        chk("abort_done3",  {31'b0, done3},  32'd0);
        chk("abort_rd1",    rd1,             32'h0);
        mrd[0] = 32'h0;
        mrd[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done3}, 32'd0);
        end
        run_op(1, 1'b0, 3'b010, 32'h18, 32'h0);
        run_op(0, 1'b1, 3'b000, 32'h7, 32'hA5);
        run_op(0, 1'b0, 3'b000, 32'h7, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
